// File: rtl/stitch_pipeline_egress_fifo.sv
// -----------------------------------------------------------------------------
// stitch_pipeline_egress_fifo
//
// Credit-based egress buffer for a stitched valid pipeline that cannot stall.
// The producer's issue (in_valid of the pipeline) is gated by a credit counter,
// so the items in flight plus the items buffered never exceed DEPTH. Pipeline
// results are captured into a DEPTH-entry FIFO. The FIFO is presented to the
// consumer on a ready/valid interface.
//
// Ports:
//   clk            - clock, all state updates on posedge
//   rst            - async active-high reset; shared with the upstream pipeline
//   src_valid      - producer has an item to issue
//   src_ready      - a credit is available (used < DEPTH)
//   pipe_in_valid  - issue strobe to the pipeline (src_valid & src_ready)
//   pipe_out_valid - final-stage valid from the pipeline (push request)
//   pipe_out_data  - final-stage data from the pipeline
//   out_valid      - FIFO not empty
//   out_ready      - consumer accepts the head entry
//   out_data       - FIFO head entry
//   occupancy      - number of entries stored in the FIFO
//   protocol_err   - sticky flag: overflow push or pop with no credit in use
// -----------------------------------------------------------------------------
module stitch_pipeline_egress_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         src_valid,
  output logic                         src_ready,
  output logic                         pipe_in_valid,
  input  logic                         pipe_out_valid,
  input  logic [DATA_WIDTH-1:0]        pipe_out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         protocol_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         used;
  logic                  err_q;

  logic issue;
  logic pop;
  logic full;
  logic push_ok;
  logic overflow;
  logic stale_pop;

  // The credit check looks only at registered state. A credit freed by a pop
  // becomes usable one cycle later. So the issue-to-credit-return loop is
  // pipeline latency + 2 cycles.
  assign src_ready     = (used < DEPTH_C);
  assign issue         = src_valid & src_ready;
  assign pipe_in_valid = issue;

  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign full      = (count == DEPTH_C);

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign push_ok   = pipe_out_valid & (~full | pop);
  assign overflow  = pipe_out_valid & full & ~pop;
  assign stale_pop = pop & (used == '0);

  assign out_data     = mem[rd_ptr];
  assign occupancy    = count;
  assign protocol_err = err_q;

  // Storage has no reset. Its contents are meaningless while count is zero.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= pipe_out_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      used   <= '0;
      err_q  <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
      end

      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      // A pop with no credit outstanding is a leftover result from before a reset.
      // It returns no credit, so used only follows the issue.
      case ({issue, pop})
        2'b10:   used <= used + CW'(1);
        2'b01:   used <= stale_pop ? '0 : used - CW'(1);
        2'b11:   used <= stale_pop ? CW'(1) : used;
        default: used <= used;
      endcase

      if (overflow || stale_pop) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule
